// File: rtl/masked_decoder_pipe_if.sv
// masked_decoder_pipe_if: valid/ready bus for the masked decoder pipe.
// Input side: flush, in_valid/in_ready, in_mode, port_a, port_b, port_r.
// Output side: out_valid/out_ready, port_c, occupancy.
interface masked_decoder_pipe_if #(
  parameter int N = 3,
  parameter int W = 32
);
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_mode;
  logic [N*W-1:0] port_a;
  logic [N*W-1:0] port_b;
  logic [(N-1)*W-1:0] port_r;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] port_c;
  logic [1:0]     occupancy;
  modport master (
    output flush, in_valid, in_mode, port_a, port_b, port_r, out_ready,
    input  in_ready, out_valid, port_c, occupancy
  );
  modport slave (
    input  flush, in_valid, in_mode, port_a, port_b, port_r, out_ready,
    output in_ready, out_valid, port_c, occupancy
  );
endinterface

// File: rtl/masked_decoder_pipe.sv
// masked_decoder_pipe: two-stage masked share decoder applying op(B) onto every share of a.
// clk/rst (async, active-low) plus bus (slave): S1 holds remasked b shares, a shares and
// mode; S2 holds result shares port_c and out_valid. occupancy = beats held (0..2).
module masked_decoder_pipe #(
  parameter int D = 2,
  parameter int N = D + 1,
  parameter int W = 32
) (
  input logic clk,
  input logic rst,
  masked_decoder_pipe_if.slave bus
);
  logic [N*W-1:0] bm, a1, c_d, cr;
  logic [1:0] mode1;
  logic s1_valid, ov, s2_free, adv, acc;
  logic [W-1:0] rl, bsum, k, ai;
  // last randomness share closes the zero-sum so remasking never changes b
  always_comb begin
    rl = '0;
    for (int i = 0; i < N - 1; i++) rl ^= bus.port_r[i*W +: W];
  end
  // recombination only ever reads the registered S1 shares
  always_comb begin
    bsum = '0;
    for (int i = 0; i < N; i++) bsum ^= bm[i*W +: W];
  end
  // only share 0 absorbs B for OR/XOR, keeping the result XOR-sharing intact
  always_comb begin
    c_d = '0;
    k = '0;
    ai = '0;
    for (int i = 0; i < N; i++) begin
      ai = a1[i*W +: W];
      k = (i == 0) ? bsum : '0;
      c_d[i*W +: W] = mode1[1] ? (mode1[0] ? ai ^ k : (ai & ~bsum) ^ k)
                               : ai & (mode1[0] ? ~bsum : bsum);
    end
  end
  assign s2_free = !ov || bus.out_ready;
  assign adv = s1_valid && s2_free;
  assign bus.in_ready = rst && (!s1_valid || s2_free) && !bus.flush;
  assign acc = bus.in_valid && bus.in_ready;
  assign bus.out_valid = ov;
  assign bus.port_c = cr;
  assign bus.occupancy = {1'b0, s1_valid} + {1'b0, ov};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      ov <= 1'b0;
      cr <= '0;
      bm <= '0;
      a1 <= '0;
      mode1 <= '0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      ov <= 1'b0;
    end else begin
      if (adv) begin
        ov <= 1'b1;
        cr <= c_d;
      end else if (bus.out_ready) ov <= 1'b0;
      if (acc) begin
        bm <= bus.port_b ^ {rl, bus.port_r};
        a1 <= bus.port_a;
        mode1 <= bus.in_mode;
        s1_valid <= 1'b1;
      end else if (adv) s1_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_masked_decoder_pipe.sv
// tb_masked_decoder_pipe: randomized scoreboard bench for masked_decoder_pipe (N=3, W=8).
module tb_masked_decoder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {int t; logic [23:0] c; logic [7:0] x;} item_t;
  item_t q[$];
  logic [23:0] cur_c;
  logic [7:0] cur_x;
  logic accepted;
  logic [23:0] hold;
  masked_decoder_pipe_if #(.N(3), .W(8)) bus ();
  masked_decoder_pipe #(.D(2), .W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [23:0] model_c(input logic [23:0] a, input logic [23:0] b, input logic [1:0] m);
    logic [7:0] bv, s;
    logic [23:0] c;
    bv = b[7:0] ^ b[15:8] ^ b[23:16];
    for (int i = 0; i < 3; i++) begin
      s = a[i*8 +: 8];
      case (m)
        2'd0: c[i*8 +: 8] = s & bv;
        2'd1: c[i*8 +: 8] = s & ~bv;
        2'd2: c[i*8 +: 8] = (i == 0) ? ((s & ~bv) ^ bv) : (s & ~bv);
        default: c[i*8 +: 8] = (i == 0) ? (s ^ bv) : s;
      endcase
    end
    return c;
  endfunction
  function automatic logic [7:0] model_x(input logic [23:0] a, input logic [23:0] b, input logic [1:0] m);
    logic [7:0] av, bv;
    av = a[7:0] ^ a[15:8] ^ a[23:16];
    bv = b[7:0] ^ b[15:8] ^ b[23:16];
    case (m)
      2'd0: return av & bv;
      2'd1: return av & ~bv;
      2'd2: return av | bv;
      default: return av ^ bv;
    endcase
  endfunction
  task automatic set_beat(input logic [23:0] a, input logic [23:0] b, input logic [15:0] r,
                          input logic [1:0] m, input logic [7:0] x);
    bus.port_a = a;
    bus.port_b = b;
    bus.port_r = r;
    bus.in_mode = m;
    cur_c = model_c(a, b, m);
    cur_x = x;
  endtask
  task automatic rand_beat();
    logic [23:0] a, b;
    logic [1:0] m;
    a = 24'($urandom);
    b = 24'($urandom);
    m = 2'($urandom_range(0, 3));
    set_beat(a, b, 16'($urandom), m, model_x(a, b, m));
  endtask
  task automatic tick();
    logic er, eo;
    @(negedge clk);
    er = rst && !bus.flush && (q.size() < 2 || bus.out_ready);
    eo = q.size() > 0 && cyc >= q[0].t + 1;
    check("in_ready", 32'(bus.in_ready), 32'(er));
    check("occupancy", 32'(bus.occupancy), 32'(q.size()));
    check("out_valid", 32'(bus.out_valid), 32'(eo));
    if (eo && bus.out_ready) begin
      check("port_c", 32'(bus.port_c), 32'(q[0].c));
      check("recombined", 32'(bus.port_c[7:0] ^ bus.port_c[15:8] ^ bus.port_c[23:16]), 32'(q[0].x));
      void'(q.pop_front());
    end
    accepted = bus.in_valid && er;
    if (accepted) q.push_back('{t: cyc + 1, c: cur_c, x: cur_x});
    if (bus.flush && rst) q.delete();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_beat('0, '0, '0, 2'd0, 8'h00);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_port_c", 32'(bus.port_c), 32'd0);
    check("rst_occupancy", 32'(bus.occupancy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    set_beat({8'h00, 8'h3C, 8'h5A}, {8'h00, 8'h0F, 8'hF0}, {8'h22, 8'h11}, 2'd0, 8'h66);
    tick();
    set_beat({8'h00, 8'h3C, 8'h5A}, {8'h00, 8'h0A, 8'h05}, {8'h22, 8'h11}, 2'd1, 8'h60);
    tick();
    set_beat({8'h00, 8'h3C, 8'h5A}, {8'h0C, 8'h0A, 8'h09}, {8'h5E, 8'hA7}, 2'd2, 8'h6F);
    tick();
    set_beat({8'h00, 8'h3C, 8'h5A}, {8'h00, 8'h00, 8'h0F}, {8'h33, 8'hC4}, 2'd3, 8'h69);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_beat();
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    rand_beat();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (accepted) rand_beat();
    end
    hold = bus.port_c;
    repeat (2) begin
      tick();
      check("stall_hold", 32'(bus.port_c), 32'(hold));
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    repeat (4) tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    rand_beat();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (accepted) rand_beat();
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("flush_occupancy", 32'(bus.occupancy), 32'd0);
    repeat (3) tick();
    bus.in_valid = 1'b1;
    rand_beat();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (accepted) rand_beat();
    end
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_port_c", 32'(bus.port_c), 32'd0);
    check("arst_occupancy", 32'(bus.occupancy), 32'd0);
    q.delete();
    tick();
    rst = 1'b1;
    rand_beat();
    for (int i = 0; i < 400; i++) begin
      tick();
      if (accepted || bus.in_valid == 1'b0) rand_beat();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush = ($urandom_range(0, 31) == 0);
    end
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
